// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier.
// One multiplier triplet is consumed per RUN cycle; the selected partial
// product is shifted into place and accumulated at 2*WIDTH bits. Operands
// enter through a valid/ready handshake in IDLE, and the product leaves
// through a valid/ready handshake in DONE.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8   // even, >= 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [4:0]         pp_sel,
    output logic               busy
);

    localparam int ITER = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [PW-1:0] PP_ONE = 1;

    // One-hot select encoding {minus_two, two, minus_one, one, zero}
    localparam logic [4:0] SEL_ZERO = 5'b00001;
    localparam logic [4:0] SEL_ONE  = 5'b00010;
    localparam logic [4:0] SEL_M1   = 5'b00100;
    localparam logic [4:0] SEL_TWO  = 5'b01000;
    localparam logic [4:0] SEL_M2   = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   a_ext;      // multiplicand, sign-extended to product width
    logic [WIDTH:0]  q;          // {multiplier, 1'b0}, shifted right 2 per step
    logic [PW-1:0]   acc;
    logic [CW-1:0]   count;

    logic [4:0]      sel;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   pp_shifted;
    logic [PW-1:0]   acc_next;

    // Booth decode of the low triplet of the scanned multiplier
    always_comb begin
        sel = SEL_ZERO;
        case (q[2:0])
            3'b000, 3'b111: sel = SEL_ZERO;
            3'b001, 3'b010: sel = SEL_ONE;
            3'b011:         sel = SEL_TWO;
            3'b100:         sel = SEL_M2;
            3'b101, 3'b110: sel = SEL_M1;
            default:        sel = SEL_ZERO;
        endcase
    end

    // Partial product selection; negation is invert-plus-one at full width
    always_comb begin
        pp = '0;
        case (sel)
            SEL_ONE: pp = a_ext;
            SEL_TWO: pp = a_ext << 1;
            SEL_M1:  pp = (~a_ext) + PP_ONE;
            SEL_M2:  pp = (~(a_ext << 1)) + PP_ONE;
            default: pp = '0;
        endcase
    end

    // Weight the partial product by 4^count and fold it into the running sum
    always_comb begin
        pp_shifted = pp << {count, 1'b0};
        acc_next   = acc + pp_shifted;
    end

    assign pp_sel = (state == RUN) ? sel : 5'b00000;

    // Control FSM and datapath registers; handshake outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            a_ext     <= '0;
            q         <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_ext    <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                        q        <= {multiplier, 1'b0};
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= $unsigned($signed(q) >>> 2);
                    count <= count + CW'(1);
                    if (count == CW'(ITER - 1)) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // The cycle after the output handshake is spent in IDLE
                    // before a new operand can be taken.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: directed scenarios on a WIDTH=8 instance and
// randomized traffic with output stalls on WIDTH=8 and WIDTH=16 instances,
// checked against plain signed multiplication.
module tb_booth_r4_seq_mult;

    localparam logic [4:0] S_ZERO = 5'b00001;
    localparam logic [4:0] S_ONE  = 5'b00010;
    localparam logic [4:0] S_M1   = 5'b00100;
    localparam logic [4:0] S_TWO  = 5'b01000;
    localparam logic [4:0] S_M2   = 5'b10000;
    localparam int NRAND = 2000;
    localparam int MAXC  = 80000;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  mcand8, mplier8;
    logic [15:0] product8;
    logic [4:0]  pp_sel8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] mcand16, mplier16;
    logic [31:0] product16;
    logic [4:0]  pp_sel16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp8  [$];
    logic [31:0] exp16 [$];

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .multiplicand(mcand8), .multiplier(mplier8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .pp_sel(pp_sel8), .busy(busy8)
    );

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .multiplicand(mcand16), .multiplier(mplier16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .product(product16), .pp_sel(pp_sel16), .busy(busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1);
    end

    // Drive one operand pair on the 8-bit DUT and observe it until out_valid.
    // Leaves out_ready low, so the product is held in DONE on return.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [3:0][4:0] sel, output int lat,
                        output logic [15:0] p);
        int n;
        @(negedge clk);
        mcand8 = a; mplier8 = b; in_valid8 = 1'b1; out_ready8 = 1'b0;
        n = 0;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);          // accept edge
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = -1; p = 'x; sel = '0;
        for (int k = 1; k <= 20; k++) begin
            if (lat < 0) begin
                if (k <= 4) sel[k-1] = pp_sel8;
                if (out_valid8) begin lat = k; p = product8; end
                else @(negedge clk);
            end
        end
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid8 = 0; out_ready8 = 0; mcand8 = 0; mplier8 = 0;
        in_valid16 = 0; out_ready16 = 0; mcand16 = 0; mplier16 = 0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
        n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
        n_cmp++; if (pp_sel8 !== 5'b0) begin n_bad++; $display("FAIL reset_pp_sel: got %b want 00000", pp_sel8); end
        n_cmp++; if (product8 !== 16'h0) begin n_bad++; $display("FAIL reset_product: got %h want 0000", product8); end
        n_cmp++; if (in_ready16 !== 1'b1 || product16 !== 32'h0) begin n_bad++; $display("FAIL reset_w16: in_ready %b product %h want 1 / 0", in_ready16, product16); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: in_ready %b out_valid %b want 1 / 0", in_ready8, out_valid8); end
    endtask

    task automatic test_basic();
        logic [3:0][4:0] sel;
        logic [3:0][4:0] want;
        int lat;
        logic [15:0] p;
        want = {S_ZERO, S_ZERO, S_ONE, S_M1};   // index 0 is the first RUN cycle
        run8(8'd7, 8'd3, sel, lat, p);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (sel[i] !== want[i]) begin n_bad++; $display("FAIL basic_pp_sel[%0d]: got %b want %b", i, sel[i], want[i]); end
        end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_cmp++; if (p !== 16'h0015) begin n_bad++; $display("FAIL basic_product: got %h want 0015", p); end
        n_cmp++; if (pp_sel8 !== 5'b0 || busy8 !== 1'b1 || in_ready8 !== 1'b0) begin n_bad++; $display("FAIL basic_done_flags: pp_sel %b busy %b in_ready %b want 00000/1/0", pp_sel8, busy8, in_ready8); end
        consume8();
        n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_after_handshake: out_valid %b in_ready %b busy %b want 0/1/0", out_valid8, in_ready8, busy8); end
        n_cmp++; if (product8 !== 16'h0015) begin n_bad++; $display("FAIL basic_product_hold_idle: got %h want 0015", product8); end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [5];
        logic [7:0]  tb [5];
        logic [15:0] te [5];
        logic [3:0][4:0] sel;
        int lat;
        logic [15:0] p;
        ta = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'hB3};
        tb = '{8'h80, 8'h7F, 8'hFF, 8'hB3, 8'h00};
        te = '{16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            run8(ta[i], tb[i], sel, lat, p);
            n_cmp++; if (p !== te[i]) begin n_bad++; $display("FAIL corner_product[%0d]: A=%h B=%h got %h want %h", i, ta[i], tb[i], p, te[i]); end
            if (i == 4) begin
                for (int k = 0; k < 4; k++) begin
                    n_cmp++; if (sel[k] !== S_ZERO) begin n_bad++; $display("FAIL corner_zero_sel[%0d]: got %b want %b", k, sel[k], S_ZERO); end
                end
            end
            consume8();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0][4:0] sel;
        int lat;
        int n;
        logic [15:0] p;
        run8(8'd5, 8'hFA, sel, lat, p);
        n_cmp++; if (p !== 16'hFFE2) begin n_bad++; $display("FAIL bp_product: got %h want ffe2", p); end
        mcand8 = 8'd3; mplier8 = 8'd4; in_valid8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (product8 !== 16'hFFE2 || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold[%0d]: product %h in_ready %b out_valid %b want ffe2/0/1", i, product8, in_ready8, out_valid8);
            end
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin n_bad++; $display("FAIL bp_idle_gap: in_ready %b out_valid %b busy %b want 1/0/0", in_ready8, out_valid8, busy8); end
        @(negedge clk);
        in_valid8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin n_bad++; $display("FAIL bp_accept_next: busy %b in_ready %b want 1/0", busy8, in_ready8); end
        n = 0;
        while (!out_valid8 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (out_valid8 !== 1'b1 || product8 !== 16'h000C) begin n_bad++; $display("FAIL bp_second_product: out_valid %b product %h want 1/000c", out_valid8, product8); end
        consume8();
    endtask

    task automatic test_reset_midrun();
        int seen;
        @(negedge clk);
        mcand8 = 8'd33; mplier8 = 8'hD3; in_valid8 = 1'b1;
        @(posedge clk);          // accept edge
        @(negedge clk);          // first RUN cycle
        in_valid8 = 1'b0;
        @(negedge clk);          // second RUN cycle
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_flags: in_ready %b busy %b out_valid %b want 1/0/0", in_ready8, busy8, out_valid8); end
        n_cmp++; if (pp_sel8 !== 5'b0 || product8 !== 16'h0) begin n_bad++; $display("FAIL midrun_reset_data: pp_sel %b product %h want 00000/0000", pp_sel8, product8); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrun_no_stale_output: %0d bad cycles, want 0", seen); end
    endtask

    task automatic test_random();
        fork
            begin : prod8
                logic [7:0] a, b;
                int sa, sb, n;
                @(negedge clk);
                for (int i = 0; i < NRAND; i++) begin
                    a = 8'($urandom); b = 8'($urandom);
                    if ($urandom_range(15) == 0) a = 8'h80;
                    if ($urandom_range(15) == 0) b = 8'h80;
                    if ($urandom_range(3) == 0) @(negedge clk);
                    mcand8 = a; mplier8 = b; in_valid8 = 1'b1;
                    n = 0;
                    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
                    if (!in_ready8) begin
                        n_cmp++; n_bad++; $display("FAIL rand8_accept_timeout: in_ready %b want 1", in_ready8);
                        break;
                    end
                    sa = $signed(a); sb = $signed(b);
                    exp8.push_back(16'(sa * sb));
                    @(negedge clk);
                    in_valid8 = 1'b0;
                end
            end
            begin : cons8
                int got, cyc;
                logic [15:0] e;
                got = 0; cyc = 0;
                while (got < NRAND && cyc < MAXC) begin
                    @(negedge clk); cyc++;
                    out_ready8 = ($urandom_range(3) != 0);
                    if (out_valid8 && out_ready8) begin
                        n_cmp++;
                        if (exp8.size() == 0) begin n_bad++; $display("FAIL rand8_unexpected_output: product %h with nothing outstanding", product8); end
                        else begin
                            e = exp8.pop_front();
                            if (product8 !== e) begin n_bad++; $display("FAIL rand8_product[%0d]: got %h want %h", got, product8, e); end
                        end
                        got++;
                    end
                end
                out_ready8 = 1'b0;
                n_cmp++; if (got != NRAND) begin n_bad++; $display("FAIL rand8_output_count: got %0d want %0d", got, NRAND); end
            end
            begin : prod16
                logic [15:0] a, b;
                int sa, sb, n;
                @(negedge clk);
                for (int i = 0; i < NRAND; i++) begin
                    a = 16'($urandom); b = 16'($urandom);
                    if ($urandom_range(15) == 0) a = 16'h8000;
                    if ($urandom_range(15) == 0) b = 16'h8000;
                    if ($urandom_range(3) == 0) @(negedge clk);
                    mcand16 = a; mplier16 = b; in_valid16 = 1'b1;
                    n = 0;
                    while (!in_ready16 && n < 200) begin @(negedge clk); n++; end
                    if (!in_ready16) begin
                        n_cmp++; n_bad++; $display("FAIL rand16_accept_timeout: in_ready %b want 1", in_ready16);
                        break;
                    end
                    sa = $signed(a); sb = $signed(b);
                    exp16.push_back(32'(sa * sb));
                    @(negedge clk);
                    in_valid16 = 1'b0;
                end
            end
            begin : cons16
                int got, cyc;
                logic [31:0] e;
                got = 0; cyc = 0;
                while (got < NRAND && cyc < MAXC) begin
                    @(negedge clk); cyc++;
                    out_ready16 = ($urandom_range(3) != 0);
                    if (out_valid16 && out_ready16) begin
                        n_cmp++;
                        if (exp16.size() == 0) begin n_bad++; $display("FAIL rand16_unexpected_output: product %h with nothing outstanding", product16); end
                        else begin
                            e = exp16.pop_front();
                            if (product16 !== e) begin n_bad++; $display("FAIL rand16_product[%0d]: got %h want %h", got, product16, e); end
                        end
                        got++;
                    end
                end
                out_ready16 = 1'b0;
                n_cmp++; if (got != NRAND) begin n_bad++; $display("FAIL rand16_output_count: got %0d want %0d", got, NRAND); end
            end
        join
        n_cmp++; if (exp8.size() != 0 || exp16.size() != 0) begin n_bad++; $display("FAIL rand_leftover: w8 %0d w16 %0d outstanding, want 0/0", exp8.size(), exp16.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
